// File: rtl/frame_rr_sched.sv
// Round-robin frame scheduler: merges PORTS AXI-Stream style inputs into one
// registered output, granting a whole frame at a time with a one-cycle arbitration gap.
module frame_rr_sched #(
   parameter int PORTS      = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [PORTS*DATA_WIDTH-1:0]   s_tdata,
   input  logic [PORTS-1:0]              s_tvalid,
   input  logic [PORTS-1:0]              s_tlast,
   output logic [PORTS-1:0]              s_tready,
   output logic [DATA_WIDTH-1:0]         m_tdata,
   output logic                          m_tvalid,
   output logic                          m_tlast,
   input  logic                          m_tready,
   output logic                          grant_valid,
   output logic [$clog2(PORTS)-1:0]      grant_encoded,
   output logic [15:0]                   frame_count,
   output logic [0:0]                    state_dbg
);

   localparam int IW = $clog2(PORTS);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACTIVE = 1'b1;

   // Handshake: a beat moves on any edge where valid && ready; valid never
   // depends on ready, and s_tready depends only on registered state and m_tready.

   logic [0:0]            state;
   logic [IW-1:0]         last_grant;
   logic [IW-1:0]         next_sel;
   logic [IW-1:0]         cand;
   logic                  any_req;
   logic                  can_take;
   logic                  accept;
   logic                  accept_last;
   logic [DATA_WIDTH-1:0] g_data;

   assign state_dbg   = state;
   assign any_req     = |s_tvalid;
   assign grant_valid = (state == ACTIVE);
   assign can_take    = !m_tvalid || m_tready;
   assign g_data      = s_tdata[last_grant*DATA_WIDTH +: DATA_WIDTH];
   assign accept      = grant_valid && s_tvalid[last_grant] && can_take;
   assign accept_last = accept && s_tlast[last_grant];

   // last_grant doubles as the current grant index while ACTIVE
   assign grant_encoded = grant_valid ? last_grant : '0;

   // Walk downward so the candidate nearest to last_grant+1 is written last and wins.
   always_comb begin
      next_sel = last_grant;
      cand     = '0;
      for (int i = PORTS; i >= 1; i--) begin
         cand = IW'((int'(last_grant) + i) % PORTS);
         if (s_tvalid[cand]) begin
            next_sel = cand;
         end
      end
   end

   always_comb begin
      s_tready = '0;
      if (state == ACTIVE) begin
         s_tready[last_grant] = can_take;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= IW'(PORTS - 1);
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state      <= ACTIVE;
                  last_grant <= next_sel;
               end
            end
            ACTIVE: begin
               if (accept_last) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tlast  <= 1'b0;
      end else if (accept) begin
         m_tvalid <= 1'b1;
         m_tdata  <= g_data;
         m_tlast  <= s_tlast[last_grant];
      end else if (m_tready) begin
         m_tvalid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_count <= 16'h0000;
      end else if (m_tvalid && m_tready && m_tlast) begin
         frame_count <= frame_count + 16'h0001;
      end
   end

endmodule

// File: tb/tb_frame_rr_sched.sv
// Self-checking bench for frame_rr_sched: vector table, directed corner sequences,
// randomized traffic against a frame-level round-robin model, and counter wrap.
module tb_frame_rr_sched;

   localparam int P  = 4;
   localparam int DW = 8;

   logic              clk;
   logic              rst_n;
   logic [P*DW-1:0]   s_tdata;
   logic [P-1:0]      s_tvalid;
   logic [P-1:0]      s_tlast;
   logic [P-1:0]      s_tready;
   logic [DW-1:0]     m_tdata;
   logic              m_tvalid;
   logic              m_tlast;
   logic              m_tready;
   logic              grant_valid;
   logic [1:0]        grant_encoded;
   logic [15:0]       frame_count;
   logic [0:0]        state_dbg;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic          rst;
      logic [3:0]    vld;
      logic [31:0]   data;
      logic [3:0]    last;
      logic          mr;
      logic          e_gv;
      logic [1:0]    e_ge;
      logic          e_mv;
      logic [7:0]    e_md;
      logic          e_ml;
      logic [3:0]    e_sr;
      logic [15:0]   e_fc;
   } vec_t;

   vec_t vecs[$];

   logic [DW:0] exp_q[$];
   logic [DW:0] port_q[P][$];

   frame_rr_sched #(.PORTS(P), .DATA_WIDTH(DW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_tdata       (s_tdata),
      .s_tvalid      (s_tvalid),
      .s_tlast       (s_tlast),
      .s_tready      (s_tready),
      .m_tdata       (m_tdata),
      .m_tvalid      (m_tvalid),
      .m_tlast       (m_tlast),
      .m_tready      (m_tready),
      .grant_valid   (grant_valid),
      .grant_encoded (grant_encoded),
      .frame_count   (frame_count),
      .state_dbg     (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic do_reset();
      rst_n    = 1'b0;
      s_tvalid = '0;
      s_tlast  = '0;
      s_tdata  = '0;
      m_tready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] vld, input logic [31:0] d,
                      input logic [3:0] l, input logic mr, input logic gv,
                      input logic [1:0] ge, input logic mv, input logic [7:0] md,
                      input logic ml, input logic [3:0] sr, input logic [15:0] fc);
      vec_t v;
      v.rst = r;   v.vld = vld; v.data = d;  v.last = l;  v.mr = mr;
      v.e_gv = gv; v.e_ge = ge; v.e_mv = mv; v.e_md = md; v.e_ml = ml;
      v.e_sr = sr; v.e_fc = fc;
      vecs.push_back(v);
   endtask

   task automatic run_table();
      // 3-beat frame on port 2
      add(1, 4'b0100, 32'h0011_0000, 4'b0000, 1, 0, 0, 0, 8'h00, 0, 4'b0000, 0);
      add(0, 4'b0100, 32'h0011_0000, 4'b0000, 1, 1, 2, 0, 8'h00, 0, 4'b0100, 0);
      add(0, 4'b0100, 32'h0022_0000, 4'b0000, 1, 1, 2, 1, 8'h11, 0, 4'b0100, 0);
      add(0, 4'b0100, 32'h0033_0000, 4'b0100, 1, 1, 2, 1, 8'h22, 0, 4'b0100, 0);
      add(0, 4'b0000, 32'h0000_0000, 4'b0000, 1, 0, 0, 1, 8'h33, 1, 4'b0000, 0);
      add(0, 4'b0000, 32'h0000_0000, 4'b0000, 1, 0, 0, 0, 8'h00, 0, 4'b0000, 1);
      // all ports requesting single-beat frames: rotation 0,1,2,3,0
      add(1, 4'b1111, 32'hA3A2_A1A0, 4'b1111, 1, 0, 0, 0, 8'h00, 0, 4'b0000, 0);
      add(0, 4'b1111, 32'hA3A2_A1A0, 4'b1111, 1, 1, 0, 0, 8'h00, 0, 4'b0001, 0);
      add(0, 4'b1111, 32'hA3A2_A1A0, 4'b1111, 1, 0, 0, 1, 8'hA0, 1, 4'b0000, 0);
      add(0, 4'b1111, 32'hA3A2_A1A0, 4'b1111, 1, 1, 1, 0, 8'h00, 0, 4'b0010, 1);
      add(0, 4'b1111, 32'hA3A2_A1A0, 4'b1111, 1, 0, 0, 1, 8'hA1, 1, 4'b0000, 1);
      add(0, 4'b1111, 32'hA3A2_A1A0, 4'b1111, 1, 1, 2, 0, 8'h00, 0, 4'b0100, 2);
      add(0, 4'b1111, 32'hA3A2_A1A0, 4'b1111, 1, 0, 0, 1, 8'hA2, 1, 4'b0000, 2);
      add(0, 4'b1111, 32'hA3A2_A1A0, 4'b1111, 1, 1, 3, 0, 8'h00, 0, 4'b1000, 3);
      add(0, 4'b1111, 32'hA3A2_A1A0, 4'b1111, 1, 0, 0, 1, 8'hA3, 1, 4'b0000, 3);
      add(0, 4'b1111, 32'hA3A2_A1A0, 4'b1111, 1, 1, 0, 0, 8'h00, 0, 4'b0001, 4);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) do_reset();
         s_tvalid = vecs[i].vld;
         s_tdata  = vecs[i].data;
         s_tlast  = vecs[i].last;
         m_tready = vecs[i].mr;
         @(negedge clk);
         chk($sformatf("row%0d_gv", i), grant_valid, vecs[i].e_gv);
         chk($sformatf("row%0d_ge", i), grant_encoded, vecs[i].e_ge);
         chk($sformatf("row%0d_mv", i), m_tvalid, vecs[i].e_mv);
         chk($sformatf("row%0d_sr", i), s_tready, vecs[i].e_sr);
         chk($sformatf("row%0d_fc", i), frame_count, vecs[i].e_fc);
         if (vecs[i].e_mv) begin
            chk($sformatf("row%0d_md", i), m_tdata, vecs[i].e_md);
            chk($sformatf("row%0d_ml", i), m_tlast, vecs[i].e_ml);
         end
         next_cycle();
      end
   endtask

   // ---------------- directed sequences ----------------
   task automatic run_stall();
      do_reset();
      s_tvalid = 4'b0010; s_tdata = 32'h0000_5100; s_tlast = 4'b0000; m_tready = 1'b1;
      @(negedge clk); next_cycle();
      @(negedge clk);
      chk("stall_ge", grant_encoded, 1);
      chk("stall_sr0", s_tready, 4'b0010);
      next_cycle();
      s_tdata = 32'h0000_5200; m_tready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("stall_hold_md%0d", k), m_tdata, 8'h51);
         chk($sformatf("stall_hold_mv%0d", k), m_tvalid, 1);
         chk($sformatf("stall_hold_sr%0d", k), s_tready, 4'b0000);
         next_cycle();
      end
      m_tready = 1'b1;
      @(negedge clk);
      chk("stall_release_sr", s_tready, 4'b0010);
      chk("stall_release_md", m_tdata, 8'h51);
      next_cycle();
      s_tdata = 32'h0000_5300;
      @(negedge clk); chk("stall_b2", m_tdata, 8'h52); next_cycle();
      s_tdata = 32'h0000_5400; s_tlast = 4'b0010;
      @(negedge clk); chk("stall_b3", m_tdata, 8'h53); next_cycle();
      s_tvalid = '0; s_tlast = '0;
      @(negedge clk);
      chk("stall_b4", {m_tvalid, m_tlast, m_tdata}, {2'b11, 8'h54});
      next_cycle();
      @(negedge clk);
      chk("stall_fc", frame_count, 1);
      chk("stall_mv_off", m_tvalid, 0);
   endtask

   task automatic run_drop_valid();
      do_reset();
      s_tvalid = 4'b1001; s_tdata = 32'h3F00_0001; s_tlast = 4'b1000; m_tready = 1'b1;
      @(negedge clk); next_cycle();
      @(negedge clk); chk("drop_ge_c1", {grant_valid, grant_encoded}, 3'b100); next_cycle();
      s_tvalid = 4'b1000;
      @(negedge clk);
      chk("drop_ge_c2", {grant_valid, grant_encoded}, 3'b100);
      chk("drop_sr_c2", s_tready, 4'b0001);
      chk("drop_md_c2", m_tdata, 8'h01);
      next_cycle();
      @(negedge clk);
      chk("drop_ge_c3", {grant_valid, grant_encoded}, 3'b100);
      chk("drop_mv_c3", m_tvalid, 0);
      next_cycle();
      s_tvalid = 4'b1001; s_tdata = 32'h3F00_0002;
      @(negedge clk); chk("drop_ge_c4", {grant_valid, grant_encoded}, 3'b100); next_cycle();
      s_tdata = 32'h3F00_0003;
      @(negedge clk); chk("drop_md_c5", m_tdata, 8'h02); next_cycle();
      s_tdata = 32'h3F00_0004; s_tlast = 4'b1001;
      @(negedge clk); chk("drop_md_c6", m_tdata, 8'h03); next_cycle();
      s_tvalid = 4'b1000; s_tlast = 4'b1000;
      @(negedge clk);
      chk("drop_gap_gv", grant_valid, 0);
      chk("drop_last_beat", {m_tlast, m_tdata}, {1'b1, 8'h04});
      next_cycle();
      @(negedge clk);
      chk("drop_next_grant", {grant_valid, grant_encoded}, 3'b111);
      chk("drop_next_sr", s_tready, 4'b1000);
      next_cycle();
      s_tvalid = '0;
      @(negedge clk);
      chk("drop_p3_beat", {m_tlast, m_tdata}, {1'b1, 8'h3F});
      chk("drop_fc", frame_count, 1);
      next_cycle();
      @(negedge clk);
      chk("drop_fc2", frame_count, 2);
   endtask

   task automatic run_mid_reset();
      do_reset();
      s_tvalid = 4'b0100; s_tdata = 32'h0021_0000; s_tlast = 4'b0000; m_tready = 1'b1;
      @(negedge clk); next_cycle();
      @(negedge clk); chk("mrst_ge", grant_encoded, 2); next_cycle();
      s_tdata = 32'h0022_0000; rst_n = 1'b0;
      @(negedge clk); chk("mrst_b1", m_tdata, 8'h21); next_cycle();
      rst_n = 1'b1; s_tvalid = 4'b1010; s_tdata = 32'h3B00_1B00; s_tlast = 4'b1010;
      @(negedge clk);
      chk("mrst_gv", grant_valid, 0);
      chk("mrst_ge0", grant_encoded, 0);
      chk("mrst_mout", {m_tvalid, m_tlast, m_tdata}, 10'h000);
      chk("mrst_fc", frame_count, 0);
      chk("mrst_sr", s_tready, 4'b0000);
      next_cycle();
      @(negedge clk); chk("mrst_regrant", {grant_valid, grant_encoded}, 3'b101); next_cycle();
      s_tvalid = 4'b1000;
      @(negedge clk); chk("mrst_p1_beat", m_tdata, 8'h1B); next_cycle();
      s_tvalid = '0; s_tlast = '0;
      next_cycle();
   endtask

   // ---------------- randomized traffic vs frame-level model ----------------
   task automatic run_random();
      logic [DW:0] mq[P][$];
      logic [DW:0] beat;
      logic [P-1:0] acc;
      logic [P-1:0] mid;
      int lg, sel, nfr, cyc, len;

      do_reset();
      nfr = 0;
      for (int p = 0; p < P; p++) begin
         port_q[p].delete();
         for (int f = 0; f < 3; f++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++)
               port_q[p].push_back({(b == len - 1), DW'($urandom)});
            nfr++;
         end
         mq[p] = port_q[p];
      end

      // Expected output order: frames taken whole, next port with work after the last winner.
      exp_q.delete();
      lg = P - 1;
      for (int k = 0; k < nfr; k++) begin
         sel = -1;
         for (int i = P; i >= 1; i--)
            if (mq[(lg + i) % P].size() != 0) sel = (lg + i) % P;
         do begin
            beat = mq[sel].pop_front();
            exp_q.push_back(beat);
         end while (!beat[DW]);
         lg = sel;
      end

      mid = '0;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 4000) begin
         for (int p = 0; p < P; p++) begin
            if (port_q[p].size() != 0) begin
               s_tvalid[p]         = !(mid[p] && ($urandom_range(0, 3) == 0));
               s_tdata[p*DW +: DW] = port_q[p][0][DW-1:0];
               s_tlast[p]          = port_q[p][0][DW];
            end else begin
               s_tvalid[p] = 1'b0;
               s_tlast[p]  = 1'b0;
            end
         end
         m_tready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         chk("rnd_ready_onehot", ($countones(s_tready) <= 1), 1);
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) chk("rnd_extra_beat", 1, 0);
            else chk("rnd_beat", {m_tlast, m_tdata}, exp_q.pop_front());
         end
         acc = s_tvalid & s_tready;
         next_cycle();
         for (int p = 0; p < P; p++) begin
            if (acc[p]) begin
               beat   = port_q[p].pop_front();
               mid[p] = !beat[DW];
            end
         end
         cyc++;
      end
      chk("rnd_timeout_left", exp_q.size(), 0);
      s_tvalid = '0;
      s_tlast  = '0;
      @(negedge clk);
      chk("rnd_frame_count", frame_count, nfr);
      next_cycle();
   endtask

   // ---------------- frame counter wrap ----------------
   task automatic run_wrap();
      int hs, cyc;
      do_reset();
      s_tvalid = 4'b0001; s_tdata = 32'h0000_005A; s_tlast = 4'b0001; m_tready = 1'b1;
      hs = 0; cyc = 0;
      while (hs < 65536 && cyc < 140000) begin
         @(negedge clk);
         if (m_tvalid && m_tready && m_tlast) begin
            hs++;
            if (hs == 1)     chk("wrap_first", frame_count, 0);
            if (hs == 65536) chk("wrap_before", frame_count, 16'hFFFF);
         end
         next_cycle();
         cyc++;
      end
      chk("wrap_timeout", hs, 65536);
      s_tvalid = '0;
      @(negedge clk);
      chk("wrap_after", frame_count, 16'h0000);
   endtask

   initial begin
      rst_n    = 1'b0;
      s_tvalid = '0;
      s_tlast  = '0;
      s_tdata  = '0;
      m_tready = 1'b1;
      run_table();
      run_stall();
      run_drop_valid();
      run_mid_reset();
      run_random();
      run_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
